sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Shares the single SDRAM memory controller between `NUM_PORTS` independent requesters. It grants one request at a time, round-robin. It then drives the controller's `ready`/`cmd`/`addr` inputs and write data, tracks the controller's `valid` handshake to detect completion, and returns read data plus a one-cycle response pulse to the granted port. It sits between the client logic (CPU bridge, video/DMA engines) and the memory controller, and it is the only block allowed to drive the controller's command inputs.

## Interface
- `NUM_PORTS`, default 2: number of requesters (2..8).
- `TIMEOUT`, default 64: maximum number of cycles a command may take to complete before it is abandoned.
- `clk` input 1: system clock. It is the same clock as the memory controller.
- `rst` input 1: reset, synchronous, active-high. It is shared with the memory controller.
- `req_valid` input NUM_PORTS: a port has a request pending. The port holds it until `req_ready`.
- `req_write` input NUM_PORTS: 1 means write, 0 means read. Per port.
- `req_addr` input NUM_PORTS×25: word address per port, in {bank[24:23], row[22:10], col[9:0]} form.
- `req_wdata` input NUM_PORTS×16: write data per port.
- `req_ready` output NUM_PORTS: one-hot, one-cycle accept pulse.
- `rsp_valid` output NUM_PORTS: one-hot, one-cycle completion pulse. It fires for reads and writes.
- `rsp_rdata` output 16: read data, valid while `rsp_valid` is high. It is shared by all ports.
- `err_timeout` output 1: sticky flag, set on a completion timeout and cleared only by `rst`.
- `mc_ready` output 1: command strobe to the controller.
- `mc_cmd` output 2: 00 = none, 01 = read, 10 = write. The value 11 is never driven.
- `mc_addr` output 25: address to the controller.
- `mc_wdata` output 16: write data. The top level drives it onto the controller's `dq` when `mc_cmd == 10`.
- `mc_rdata` input 16: controller `dq` as seen while `mc_cmd == 01`.
- `mc_valid` input 1: controller `valid`.

## Operation
- FSM states: INIT, ARB, ISSUE, WAIT_LOW, WAIT_HIGH, DONE.
- **INIT:** wait for `mc_valid` to be high on two consecutive cycles. A single-cycle high during the controller's init sequence is ignored. Then go to ARB.
- **ARB:**
  - If `mc_valid == 1` and any `req_valid` is set, grant the first requesting port at or after the round-robin pointer.
  - Pulse `req_ready[g]`.
  - Latch addr, wdata and write into the `mc_*` registers, and set `mc_cmd` to 01 or 10.
  - Set the pointer to (g+1) mod NUM_PORTS, then go to ISSUE.
  - Otherwise stay in ARB with `mc_cmd = 00`.
- **ISSUE:** `mc_ready = 1` for exactly one cycle, then go to WAIT_LOW.
- **WAIT_LOW:** `mc_ready = 0`. When `mc_valid == 0`, go to WAIT_HIGH.
- **WAIT_HIGH:** when `mc_valid == 1`, capture `mc_rdata` into `rsp_rdata` (reads only), then go to DONE.
- **DONE:** pulse `rsp_valid[g]`, set `mc_cmd` to 00, then go to ARB.
- `mc_cmd`, `mc_addr` and `mc_wdata` are held constant from the latch in ARB until DONE, because the controller samples them across several states.
- **Timeout:** a counter runs in WAIT_LOW and WAIT_HIGH. On reaching `TIMEOUT`, set `err_timeout`, pulse `rsp_valid[g]` with `rsp_rdata = 0`, set `mc_cmd` to 00, and go to INIT.
- Only one transaction is outstanding at a time. Requests that arrive while the FSM is not in ARB wait; they are never dropped.
- Write responses leave `rsp_rdata` unchanged.

## Timing
- **Reset values:** all outputs are 0 (`req_ready`, `rsp_valid`, `rsp_rdata`, `err_timeout`, `mc_ready`, `mc_cmd`, `mc_addr`, `mc_wdata`). The FSM is in INIT and the round-robin pointer is 0.
- **Read:** accept at cycle A, `mc_ready` at A+1, `mc_valid` low at A+2, high at A+6 (sampled), `rsp_valid` at A+7. The next accept is no earlier than A+8.
- **Write:** accept at cycle A, `mc_valid` high at A+5, `rsp_valid` at A+6.
- **Simultaneous requests:** the port closest to the pointer wins. Other ports wait at most NUM_PORTS−1 grants.
- **Same-cycle events:** `req_valid` dropping in the same cycle as the accept has no effect; the request has already been accepted.
- **Reset mid-transaction:** the in-flight request is abandoned with no `rsp_valid`. All outputs return to their reset values on the next edge and the FSM goes to INIT.
- **Timeout boundary:** at exactly `TIMEOUT` cycles in WAIT_*, the timeout path is taken. A completion seen in that same cycle takes precedence.

## Structure
- Package `sdram_arb_pkg`: `MC_CMD_NONE`/`MC_CMD_READ`/`MC_CMD_WRITE` constants, the FSM state enum, and the `SDRAM_ADDR_W = 25` and `SDRAM_DATA_W = 16` constants.
- Sub-module `rr_arbiter`: combinational round-robin grant from the request vector and pointer, producing a one-hot grant and an index. The pointer register lives in the parent.

## Test plan
- **Post-reset init:** after `rst`, drive `mc_valid` as 0×8, then a single 1, then 0, then steady 1. No `mc_ready` may appear before the second consecutive high; then grant port 0.
- **Single read:** port 0 reads addr 0x0123456 while the model returns 0xBEEF. Expect `mc_cmd = 01` held for cycles A..A+6, `mc_ready` only at A+1, `rsp_valid[0]` at A+7 with `rsp_rdata = 0xBEEF`.
- **Single write:** port 1 writes 0x5A5A to 0x1FFFFFF. Expect `mc_cmd = 10`, `mc_wdata = 0x5A5A` and `mc_addr = 0x1FFFFFF` held, `rsp_valid[1]` at A+6.
- **Contention:** both ports hold `req_valid` continuously for 6 transactions. Grants alternate 0,1,0,1,0,1, and no port gets two accepts in a row.
- **Timeout:** the model holds `mc_valid = 0` indefinitely. At `TIMEOUT`, `err_timeout` = 1 and `rsp_valid[g]` pulses with `rsp_rdata = 0`. `err_timeout` stays 1 until `rst`.
- **Reset mid-read:** assert `rst` at A+4. No `rsp_valid` occurs, all outputs are 0 the next cycle, and the FSM re-runs INIT.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared constants and FSM state type for the SDRAM port arbiter.
// Command encoding matches the memory controller's cmd input.
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;

  localparam logic [1:0] MC_CMD_NONE  = 2'b00;
  localparam logic [1:0] MC_CMD_READ  = 2'b01;
  localparam logic [1:0] MC_CMD_WRITE = 2'b10;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int p;
      p = int'(ptr) + i;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!any && req[p]) begin
        any      = 1'b1;
        grant[p] = 1'b1;
        idx      = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of one SDRAM controller among NUM_PORTS requesters,
// one outstanding command at a time, with a completion watchdog.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_valid,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS*SDRAM_ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*SDRAM_DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]              req_ready,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [SDRAM_DATA_W-1:0]           rsp_rdata,
  output logic                              err_timeout,
  output logic                              mc_ready,
  output logic [1:0]                        mc_cmd,
  output logic [SDRAM_ADDR_W-1:0]           mc_addr,
  output logic [SDRAM_DATA_W-1:0]           mc_wdata,
  input  logic [SDRAM_DATA_W-1:0]           mc_rdata,
  input  logic                              mc_valid
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int TW    = $clog2(TIMEOUT + 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     cur_idx;
  logic                 cur_write;
  logic                 init_hi;
  logic [TW-1:0]        cnt;

  logic [NUM_PORTS-1:0] gnt_vec;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_rr (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(gnt_vec),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      ptr         <= '0;
      cur_idx     <= '0;
      cur_write   <= 1'b0;
      init_hi     <= 1'b0;
      cnt         <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      err_timeout <= 1'b0;
      mc_ready    <= 1'b0;
      mc_cmd      <= MC_CMD_NONE;
      mc_addr     <= '0;
      mc_wdata    <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      mc_ready  <= 1'b0;
      case (state)
        // A lone high during the controller's power-up sequence must not count.
        ST_INIT: begin
          init_hi <= mc_valid;
          if (mc_valid && init_hi) state <= ST_ARB;
        end
        ST_ARB: begin
          if (mc_valid && gnt_any) begin
            req_ready <= gnt_vec;
            cur_idx   <= gnt_idx;
            cur_write <= req_write[gnt_idx];
            mc_addr   <= req_addr[int'(gnt_idx)*SDRAM_ADDR_W +: SDRAM_ADDR_W];
            mc_wdata  <= req_wdata[int'(gnt_idx)*SDRAM_DATA_W +: SDRAM_DATA_W];
            mc_cmd    <= req_write[gnt_idx] ? MC_CMD_WRITE : MC_CMD_READ;
            ptr       <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mc_ready <= 1'b1;
          cnt      <= '0;
          state    <= ST_WAIT_LOW;
        end
        // Completion in the final watchdog cycle still wins over the timeout.
        ST_WAIT_LOW, ST_WAIT_HIGH: begin
          if (state == ST_WAIT_HIGH && mc_valid) begin
            rsp_valid <= NUM_PORTS'(1) << cur_idx;
            if (!cur_write) rsp_rdata <= mc_rdata;
            mc_cmd    <= MC_CMD_NONE;
            state     <= ST_DONE;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            rsp_valid   <= NUM_PORTS'(1) << cur_idx;
            rsp_rdata   <= '0;
            mc_cmd      <= MC_CMD_NONE;
            init_hi     <= 1'b0;
            state       <= ST_INIT;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == ST_WAIT_LOW && !mc_valid) state <= ST_WAIT_HIGH;
          end
        end
        ST_DONE: state <= ST_ARB;
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a behavioural controller model
// and an accept/response scoreboard.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int NP = 2;
  localparam int TO = 16;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [NP-1:0]                req_valid = '0;
  logic [NP-1:0]                req_write = '0;
  logic [NP*SDRAM_ADDR_W-1:0]   req_addr  = '0;
  logic [NP*SDRAM_DATA_W-1:0]   req_wdata = '0;
  logic [NP-1:0]                req_ready;
  logic [NP-1:0]                rsp_valid;
  logic [SDRAM_DATA_W-1:0]      rsp_rdata;
  logic                         err_timeout;
  logic                         mc_ready;
  logic [1:0]                   mc_cmd;
  logic [SDRAM_ADDR_W-1:0]      mc_addr;
  logic [SDRAM_DATA_W-1:0]      mc_wdata;
  logic [SDRAM_DATA_W-1:0]      mc_rdata = 16'hDEAD;
  logic                         mc_valid = 1'b0;

  sdram_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err_timeout(err_timeout), .mc_ready(mc_ready), .mc_cmd(mc_cmd),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_valid(mc_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          wr;
    bit          to;
    logic [15:0] data;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          ph       = 0;
  bit          model_on = 0;
  bit          hang     = 0;
  bit          exp_err  = 0;
  logic [15:0] model_rdata = 16'h0000;
  logic [15:0] last_rd = 16'h0000;
  bit          acc_seen, rsp_seen;
  int          acc_port, acc_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input bit v, input bit w,
                         input logic [24:0] a, input logic [15:0] d);
    req_valid[p] = v;
    req_write[p] = w;
    req_addr[p*SDRAM_ADDR_W +: SDRAM_ADDR_W] = a;
    req_wdata[p*SDRAM_DATA_W +: SDRAM_DATA_W] = d;
  endtask

  // One clock: sample at the falling edge, run the controller model, score.
  task automatic step();
    bit   rst_at_edge;
    int   port;
    exp_t e;
    logic [15:0] exp_d;
    rst_at_edge = rst;
    @(negedge clk);
    cyc++;
    acc_seen = 0;
    rsp_seen = 0;
    mc_rdata = 16'hDEAD;
    if (rst_at_edge) begin
      sb.delete();
      ph      = 0;
      exp_err = 0;
      chk("rst_ctrl", 32'({req_ready, rsp_valid, err_timeout, mc_ready, mc_cmd}), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_addr", 32'(mc_addr), 32'd0);
      chk("rst_wdata", 32'(mc_wdata), 32'd0);
    end
    if (model_on) begin
      if (mc_ready) ph = 1;
      else if (ph != 0) ph++;
      if (ph >= 2) begin
        if (!hang && sb.size() != 0 && ph == (sb[0].wr ? 5 : 6)) begin
          mc_valid = 1'b1;
          mc_rdata = sb[0].data;
          ph       = 0;
        end else begin
          mc_valid = 1'b0;
        end
      end
    end
    if (req_ready != '0) begin
      port = 0;
      for (int i = 0; i < NP; i++) if (req_ready[i]) port = i;
      chk("accept_onehot", 32'($countones(req_ready)), 32'd1);
      acc_seen = 1;
      acc_port = port;
      acc_cyc  = cyc;
      e.port = port;
      e.wr   = req_write[port];
      e.to   = hang;
      e.data = model_rdata;
      e.acc  = cyc;
      chk("accept_cmd", 32'(mc_cmd), 32'(e.wr ? MC_CMD_WRITE : MC_CMD_READ));
      chk("accept_addr", 32'(mc_addr), 32'(req_addr[port*SDRAM_ADDR_W +: SDRAM_ADDR_W]));
      if (e.wr) chk("accept_wdata", 32'(mc_wdata), 32'(req_wdata[port*SDRAM_DATA_W +: SDRAM_DATA_W]));
      sb.push_back(e);
    end
    if (rsp_valid != '0) begin
      rsp_seen = 1;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_port", 32'(rsp_valid), 32'(1) << e.port);
        exp_d = e.to ? 16'h0000 : (e.wr ? last_rd : e.data);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
        last_rd = exp_d;
        chk("rsp_latency", 32'(cyc - e.acc), 32'(e.to ? TO + 1 : (e.wr ? 6 : 7)));
        if (e.to) exp_err = 1;
      end
    end
    chk("err_timeout", 32'(err_timeout), 32'(exp_err));
  endtask

  task automatic wait_accept(input int bound);
    for (int i = 0; i < bound; i++) begin
      step();
      if (acc_seen) return;
    end
    chk("accept_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int bound);
    for (int i = 0; i < bound; i++) begin
      step();
      if (rsp_seen) return;
    end
    chk("rsp_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int a0, prev_port, prev_acc;
    bit prev_rd;

    // Reset
    step();
    step();
    rst = 1'b0;

    // Post-reset init filter, then the first grant goes to port 0
    set_req(0, 1'b1, 1'b0, 25'h0123456, 16'h0000);
    model_rdata = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("init_quiet", 32'({req_ready, mc_ready}), 32'd0);
    end
    mc_valid = 1'b1; step(); chk("init_single_hi", 32'({req_ready, mc_ready}), 32'd0);
    mc_valid = 1'b0; step(); chk("init_low", 32'({req_ready, mc_ready}), 32'd0);
    mc_valid = 1'b1; step(); chk("init_hi1", 32'({req_ready, mc_ready}), 32'd0);
    step(); chk("init_hi2", 32'({req_ready, mc_ready}), 32'd0);
    model_on = 1;
    wait_accept(6);
    chk("init_grant_port0", 32'(req_ready), 32'd1);

    // Single read from port 0 (dropping req_valid at accept is harmless)
    req_valid[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("rd_cmd_held", 32'(mc_cmd), 32'(MC_CMD_READ));
      chk("rd_mc_ready", 32'(mc_ready), 32'(k == 1));
      chk("rd_no_rsp", 32'(rsp_valid), 32'd0);
    end
    step();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", 32'(rsp_rdata), 32'h0000BEEF);

    // Single write from port 1
    set_req(1, 1'b1, 1'b1, 25'h1FFFFFF, 16'h5A5A);
    wait_accept(10);
    chk("wr_grant_port1", 32'(req_ready), 32'd2);
    req_valid[1] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("wr_cmd_held", 32'(mc_cmd), 32'(MC_CMD_WRITE));
      chk("wr_addr_held", 32'(mc_addr), 32'h01FFFFFF);
      chk("wr_wdata_held", 32'(mc_wdata), 32'h00005A5A);
      chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
    end
    step();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("wr_rdata_kept", 32'(rsp_rdata), 32'h0000BEEF);
    step();

    // Contention: both ports request continuously
    set_req(0, 1'b1, 1'b0, 25'h0000100, 16'h0000);
    set_req(1, 1'b1, 1'b1, 25'h1000200, 16'h1234);
    prev_port = -1;
    prev_acc  = 0;
    prev_rd   = 0;
    for (int t = 0; t < 6; t++) begin
      model_rdata = 16'h1000 + 16'(t);
      wait_accept(14);
      chk("cont_order", 32'(acc_port), 32'(t % 2));
      if (t > 0) chk("cont_no_repeat", 32'(acc_port != prev_port), 32'd1);
      if (prev_rd) chk("cont_read_gap", 32'((acc_cyc - prev_acc) >= 8), 32'd1);
      prev_port = acc_port;
      prev_acc  = acc_cyc;
      prev_rd   = (acc_port == 0);
    end
    req_valid = '0;
    wait_rsp(12);

    // Timeout: the controller never completes
    hang = 1;
    set_req(0, 1'b1, 1'b0, 25'h0ABCDEF, 16'h0000);
    wait_accept(10);
    a0 = acc_cyc;
    req_valid[0] = 1'b0;
    wait_rsp(TO + 8);
    chk("to_latency", 32'(cyc - a0), 32'(TO + 1));
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_rdata", 32'(rsp_rdata), 32'd0);
    hang = 0;
    ph = 0;
    mc_valid = 1'b1;
    model_rdata = 16'h7777;
    set_req(1, 1'b1, 1'b0, 25'h0000777, 16'h0000);
    wait_accept(10);
    req_valid[1] = 1'b0;
    wait_rsp(10);
    chk("to_err_sticky", 32'(err_timeout), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("to_err_cleared", 32'(err_timeout), 32'd0);

    // Reset in the middle of a read
    mc_valid = 1'b1;
    model_rdata = 16'h4242;
    set_req(0, 1'b1, 1'b0, 25'h0000042, 16'h0000);
    wait_accept(10);
    for (int k = 1; k <= 4; k++) step();
    rst = 1'b1;
    mc_valid = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_quiet", 32'({req_ready, rsp_valid, mc_ready}), 32'd0);
    end
    mc_valid = 1'b1;
    step(); chk("mid_rst_init1", 32'({req_ready, rsp_valid, mc_ready}), 32'd0);
    step(); chk("mid_rst_init2", 32'({req_ready, rsp_valid, mc_ready}), 32'd0);
    wait_accept(6);
    chk("mid_rst_regrant", 32'(req_ready), 32'd1);
    req_valid[0] = 1'b0;
    wait_rsp(10);
    chk("mid_rst_rdata", 32'(rsp_rdata), 32'h00004242);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
